// File: rtl/jtag_host_driver.sv
// jtag_host_driver: JTAG host walking a TAP from Run-Test/Idle and back again.
// Define JTAG_HOST_TRST_EN to also hold trst_n low for the whole TAP reset op.
`timescale 1ns/1ps
module jtag_host_driver #(
  parameter int DIV     = 2,
  parameter int MAX_LEN = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [5:0]         cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               busy,
  output logic               tck,
  output logic               tms,
  output logic               tdi,
  input  logic               tdo,
  output logic               trst_n
);

  localparam logic [1:0] OP_RST = 2'b00;
  localparam logic [1:0] OP_IR  = 2'b01;
  localparam logic [1:0] OP_DR  = 2'b10;
  localparam logic [1:0] OP_IDL = 2'b11;

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [5:0] MAXL = 6'(MAX_LEN);
  localparam logic [MAX_LEN-1:0] ONE = {{(MAX_LEN-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOW,
    S_HIGH,
    S_DONE
  } state_e;

  state_e state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [5:0] bit_q, bit_d;
  logic [5:0] last_q, last_d;
  logic [5:0] len_q, len_d;
  logic [1:0] op_q, op_d;
  logic [MAX_LEN-1:0] data_q, data_d;
  logic [MAX_LEN-1:0] cap_q, cap_d;
  logic [MAX_LEN-1:0] rsp_q, rsp_d;
  logic tck_q, tck_d;
  logic tms_q, tms_d;
  logic tdi_q, tdi_d;

  logic [5:0] len_c, nbits_c;
  logic [1:0] cur_c;
  logic [MAX_LEN-1:0] samp_c;
  logic accept;

  function automatic logic [5:0] pre_of(input logic [1:0] op);
    return (op == OP_IR) ? 6'd4 : 6'd3;
  endfunction

  // Returns {in_shift_state, tms} for TCK bit k of a command
  function automatic logic [1:0] seq_bit(
    input logic [1:0] op,
    input logic [5:0] len,
    input logic [5:0] k
  );
    logic [5:0] pre;
    logic [1:0] r;
    pre = pre_of(op);
    r = 2'b00;
    unique case (op)
      OP_RST: r = {1'b0, k < 6'd5};
      OP_IDL: r = 2'b00;
      default: begin
        if (k < pre)
          r = {1'b0, (k == 6'd0) || ((op == OP_IR) && (k == 6'd1))};
        else if (k < pre + len)
          r = {1'b1, k == pre + len - 6'd1};
        else
          r = {1'b0, k == pre + len};
      end
    endcase
    return r;
  endfunction

  // Returns {tms, tdi} for TCK bit k
  function automatic logic [1:0] drive(
    input logic [1:0]         op,
    input logic [5:0]         len,
    input logic [MAX_LEN-1:0] d,
    input logic [5:0]         k
  );
    logic [1:0] s;
    logic [MAX_LEN-1:0] sh;
    s = seq_bit(op, len, k);
    sh = d >> (k - pre_of(op));
    return {s[0], s[1] & sh[0]};
  endfunction

  always_comb begin
    len_c = (cmd_len > MAXL) ? MAXL : cmd_len;
    nbits_c = len_c;
    unique case (cmd_op)
      OP_RST: nbits_c = 6'd6;
      OP_IR: begin
        if (len_c == 6'd0) len_c = 6'd1;
        nbits_c = len_c + 6'd6;
      end
      OP_DR: begin
        if (len_c == 6'd0) len_c = 6'd1;
        nbits_c = len_c + 6'd5;
      end
      default: nbits_c = len_c;
    endcase
  end

  assign cmd_ready = (state_q == S_IDLE) || (state_q == S_DONE);
  assign accept = cmd_valid && cmd_ready;

  // tdo is only captured in shift-state bits, at the end of the high phase
  always_comb begin
    cur_c = seq_bit(op_q, len_q, bit_q);
    samp_c = '0;
    if (cur_c[1] && tdo)
      samp_c = ONE << (bit_q - pre_of(op_q));
  end

  always_comb begin
    state_d = state_q;
    div_d = div_q;
    bit_d = bit_q;
    last_d = last_q;
    len_d = len_q;
    op_d = op_q;
    data_d = data_q;
    cap_d = cap_q;
    rsp_d = rsp_q;
    tms_d = tms_q;
    tdi_d = tdi_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (accept) begin
          op_d = cmd_op;
          len_d = len_c;
          data_d = cmd_data;
          cap_d = '0;
          bit_d = 6'd0;
          div_d = '0;
          last_d = nbits_c - 6'd1;
          if (nbits_c == 6'd0) begin
            state_d = S_DONE;
            rsp_d = '0;
          end else begin
            state_d = S_LOW;
            {tms_d, tdi_d} = drive(cmd_op, len_c, cmd_data, 6'd0);
          end
        end
      end
      S_LOW: begin
        if (div_q == DIV_LAST) begin
          state_d = S_HIGH;
          div_d = '0;
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      S_HIGH: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          cap_d = cap_q | samp_c;
          if (bit_q == last_q) begin
            state_d = S_DONE;
            rsp_d = cap_d;
          end else begin
            state_d = S_LOW;
            bit_d = bit_q + 6'd1;
            {tms_d, tdi_d} = drive(op_q, len_q, data_q, bit_q + 6'd1);
          end
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    tck_d = (state_d == S_HIGH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      div_q <= '0;
      bit_q <= '0;
      last_q <= '0;
      len_q <= '0;
      op_q <= OP_IDL;
      data_q <= '0;
      cap_q <= '0;
      rsp_q <= '0;
      tck_q <= 1'b0;
      tms_q <= 1'b1;
      tdi_q <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q <= div_d;
      bit_q <= bit_d;
      last_q <= last_d;
      len_q <= len_d;
      op_q <= op_d;
      data_q <= data_d;
      cap_q <= cap_d;
      rsp_q <= rsp_d;
      tck_q <= tck_d;
      tms_q <= tms_d;
      tdi_q <= tdi_d;
    end
  end

  assign rsp_valid = (state_q == S_DONE);
  assign busy = (state_q == S_LOW) || (state_q == S_HIGH);
  assign rsp_data = rsp_q;
  assign tck = tck_q;
  assign tms = tms_q;
  assign tdi = tdi_q;

`ifdef JTAG_HOST_TRST_EN
  assign trst_n = !((op_q == OP_RST) && (state_q != S_IDLE));
`else
  assign trst_n = 1'b1;
`endif

endmodule

// File: tb/tb_jtag_host_driver.sv
// Scoreboard bench for jtag_host_driver against a small reference TAP.
// Expected responses are queued at issue time and popped by a monitor.
`timescale 1ns/1ps
module tb_jtag_host_driver;

  localparam int DIV = 2;
  localparam int ML  = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cmd_valid = 1'b0;
  logic cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [5:0] cmd_len = 6'd0;
  logic [ML-1:0] cmd_data = '0;
  logic rsp_valid;
  logic [ML-1:0] rsp_data;
  logic busy, tck, tms, tdi, trst_n;
  logic tdo = 1'b0;

  jtag_host_driver #(.DIV(DIV), .MAX_LEN(ML)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
    .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo), .trst_n(trst_n)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int unsigned cyc = 0;
  int trst_low = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (trst_n === 1'b0) trst_low++;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference TAP: 8-bit DR, 4-bit IR capturing 0001
  typedef enum logic [3:0] {
    TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PADR, EX2DR, UPDR,
    SELIR, CAPIR, SHIR, EX1IR, PAIR, EX2IR, UPIR
  } tap_e;

  tap_e st = RTI;
  logic [7:0] dr = 8'h3C, dr_sr = 8'h00;
  logic [3:0] ir = 4'hE, ir_sr = 4'h0;
  logic force_mode = 1'b0;
  logic [31:0] pat = '0;
  int pcnt = 0;
  logic tms_log[$];

  function automatic tap_e tap_next(input tap_e s, input logic m);
    case (s)
      TLR:   return m ? TLR   : RTI;
      RTI:   return m ? SELDR : RTI;
      SELDR: return m ? SELIR : CAPDR;
      CAPDR: return m ? EX1DR : SHDR;
      SHDR:  return m ? EX1DR : SHDR;
      EX1DR: return m ? UPDR  : PADR;
      PADR:  return m ? EX2DR : PADR;
      EX2DR: return m ? UPDR  : SHDR;
      UPDR:  return m ? SELDR : RTI;
      SELIR: return m ? TLR   : CAPIR;
      CAPIR: return m ? EX1IR : SHIR;
      SHIR:  return m ? EX1IR : SHIR;
      EX1IR: return m ? UPIR  : PAIR;
      PAIR:  return m ? EX2IR : PAIR;
      EX2IR: return m ? UPIR  : SHIR;
      default: return m ? SELDR : RTI;
    endcase
  endfunction

  always @(posedge tck) begin
    tms_log.push_back(tms);
    case (st)
      TLR:   ir = 4'hE;
      CAPDR: dr_sr = dr;
      SHDR:  dr_sr = {tdi, dr_sr[7:1]};
      UPDR:  dr = dr_sr;
      CAPIR: ir_sr = 4'b0001;
      SHIR:  ir_sr = {tdi, ir_sr[3:1]};
      UPIR:  ir = ir_sr;
      default: ;
    endcase
    st = tap_next(st, tms);
  end

  always @(negedge tck) begin
    if (force_mode) begin
      tdo = 1'b0;
      if (st == SHDR && pcnt < 32) begin
        tdo = pat[pcnt];
        pcnt++;
      end
    end else begin
      tdo = (st == SHDR) ? dr_sr[0] : (st == SHIR) ? ir_sr[0] : 1'b0;
    end
  end

  typedef struct {
    int unsigned at;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q[$];

  always @(negedge clk) begin
    if (rst_n && rsp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rsp_cycle", 64'(cyc), 64'(e.at));
        chk("rsp_data", 64'(rsp_data), 64'(e.data));
      end
    end
  end

  function automatic logic [63:0] log_bits();
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < tms_log.size() && i < 64; i++) v[i] = tms_log[i];
    return v;
  endfunction

  task automatic send(input logic [1:0] op, input logic [5:0] len,
                      input logic [31:0] data, input int nbits,
                      input logic [31:0] exp_data, input bit want);
    int n;
    @(negedge clk);
    tms_log.delete();
    cmd_op = op;
    cmd_len = len;
    cmd_data = data;
    cmd_valid = 1'b1;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (want)
      exp_q.push_back('{at: cyc + 1 + 2 * DIV * nbits, data: exp_data});
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk(name, 64'(exp_q.size()), 64'd0);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_data", 64'(rsp_data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_tck", 64'(tck), 64'd0);
    chk("rst_tms", 64'(tms), 64'd1);
    chk("rst_tdi", 64'(tdi), 64'd0);
    chk("rst_trst_n", 64'(trst_n), 64'd1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    trst_low = 0;
    send(2'b00, 6'd0, 32'h0, 6, 32'h0, 1'b1);
    wait_idle("reset_done");
    chk("reset_tck_n", 64'(tms_log.size()), 64'd6);
    chk("reset_tms", log_bits(), 64'h1F);
    chk("reset_tap_rti", 64'(st), 64'(RTI));
    chk("reset_tap_ir", 64'(ir), 64'hE);
`ifdef JTAG_HOST_TRST_EN
    chk("reset_trst_cycles", 64'(trst_low), 64'd25);
`else
    chk("reset_trst_cycles", 64'(trst_low), 64'd0);
`endif

    send(2'b10, 6'd8, 32'hA5, 13, 32'h3C, 1'b1);
    wait_idle("dr8_done");
    chk("dr8_tck_n", 64'(tms_log.size()), 64'd13);
    chk("dr8_tms", log_bits(), 64'h0C01);
    chk("dr8_tap_dr", 64'(dr), 64'hA5);
    chk("dr8_tap_rti", 64'(st), 64'(RTI));

    send(2'b01, 6'd4, 32'h2, 10, 32'h1, 1'b1);
    wait_idle("ir4_done");
    chk("ir4_tms", log_bits(), 64'h183);
    chk("ir4_tap_ir", 64'(ir), 64'h2);
    chk("ir4_tap_rti", 64'(st), 64'(RTI));

    send(2'b01, 6'd0, 32'h0, 7, 32'h1, 1'b1);
    wait_idle("ir0_done");
    chk("ir0_tck_n", 64'(tms_log.size()), 64'd7);
    chk("ir0_tms", log_bits(), 64'h33);

    send(2'b11, 6'd3, 32'hFFFF_FFFF, 3, 32'h0, 1'b1);
    wait_idle("idle3_done");
    chk("idle3_tck_n", 64'(tms_log.size()), 64'd3);
    chk("idle3_tms", log_bits(), 64'h0);

    send(2'b11, 6'd0, 32'h0, 0, 32'h0, 1'b1);
    wait_idle("idle0_done");
    chk("idle0_tck_n", 64'(tms_log.size()), 64'd0);

    force_mode = 1'b1;
    pat = 32'hDEADBEEF;
    pcnt = 0;
    send(2'b10, 6'd32, 32'h1234_5678, 37, 32'hDEADBEEF, 1'b1);
    @(negedge clk);
    cmd_op = 2'b00;
    cmd_valid = 1'b1;
    repeat (10) @(negedge clk);
    chk("busy_ready_low", 64'(cmd_ready), 64'd0);
    chk("busy_high", 64'(busy), 64'd1);
    cmd_valid = 1'b0;
    wait_idle("dr32_done");
    chk("dr32_tck_n", 64'(tms_log.size()), 64'd37);
    chk("dr32_tms", log_bits(), 64'hC_0000_0001);

    pat = 32'h1234_5678;
    pcnt = 0;
    send(2'b10, 6'd40, 32'h0, 37, 32'h1234_5678, 1'b1);
    wait_idle("clamp_done");
    chk("clamp_tck_n", 64'(tms_log.size()), 64'd37);
    force_mode = 1'b0;

    send(2'b10, 6'd8, 32'h5A, 13, 32'h0, 1'b0);
    n = 0;
    while (tms_log.size() < 4 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reached_bit3", 64'(tms_log.size()), 64'd4);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_tck", 64'(tck), 64'd0);
    chk("abort_tms", 64'(tms), 64'd1);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_ready", 64'(cmd_ready), 64'd1);
    chk("abort_rsp_valid", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    send(2'b00, 6'd0, 32'h0, 6, 32'h0, 1'b1);
    wait_idle("post_abort_reset_done");
    chk("post_abort_tms", log_bits(), 64'h1F);
    chk("post_abort_tap_rti", 64'(st), 64'(RTI));

    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
